// File: rtl/gol_pkg.sv
// gol_pkg: shared FSM states, Conway rule constants and neighbour-count type for the Game of Life engine
package gol_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SCAN, ST_DONE} state_t;
   typedef logic [3:0] nbr_t;
   localparam nbr_t GOL_BIRTH      = 4'd3;
   localparam nbr_t GOL_SURVIVE_LO = 4'd2;
   localparam nbr_t GOL_SURVIVE_HI = 4'd3;
endpackage

// File: rtl/gol_row_rule.sv
// gol_row_rule: combinational Conway rule over a three-row window; GOL_HWRAP_EN makes columns wrap horizontally
module gol_row_rule
   import gol_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] above,
   input  logic [WIDTH-1:0] cur,
   input  logic [WIDTH-1:0] below,
   output logic [WIDTH-1:0] nxt
);
   logic [WIDTH+1:0] ea, eb;
   logic [WIDTH-1:0] cw, ce;
`ifdef GOL_HWRAP_EN
   assign ea = {above[0], above, above[WIDTH-1]};
   assign eb = {below[0], below, below[WIDTH-1]};
   assign cw = {cur[0], cur[WIDTH-1:1]};
   assign ce = {cur[WIDTH-2:0], cur[WIDTH-1]};
`else
   assign ea = {1'b0, above, 1'b0};
   assign eb = {1'b0, below, 1'b0};
   assign cw = {1'b0, cur[WIDTH-1:1]};
   assign ce = {cur[WIDTH-2:0], 1'b0};
`endif
   for (genvar c = 0; c < WIDTH; c++) begin : g_col
      nbr_t n;
      assign n = nbr_t'(ea[c]) + nbr_t'(ea[c+1]) + nbr_t'(ea[c+2]) +
                 nbr_t'(ce[c]) + nbr_t'(cw[c]) +
                 nbr_t'(eb[c]) + nbr_t'(eb[c+1]) + nbr_t'(eb[c+2]);
      assign nxt[c] = (n == GOL_BIRTH) | (cur[c] & (n >= GOL_SURVIVE_LO) & (n <= GOL_SURVIVE_HI));
   end
endmodule

// File: rtl/gol_gen_engine.sv
// gol_gen_engine: scans the current-state rows through a sliding window and writes one Conway generation per start (GOL_HWRAP_EN selects horizontal wrap in gol_row_rule)
module gol_gen_engine
   import gol_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int REGBITS = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic [REGBITS-1:0] ra,
   input  logic [WIDTH-1:0]   rd,
   output logic               nwrite,
   output logic [REGBITS-1:0] nwa,
   output logic [WIDTH-1:0]   nwd,
   output logic               busy,
   output logic               done,
   output logic [15:0]        gen_count
);
   state_t             state_q, state_d;
   logic [WIDTH-1:0]   above_q, above_d, cur_q, cur_d, rule_row;
   logic [REGBITS-1:0] r_q, r_d;
   logic [15:0]        cnt_q, cnt_d;

   gol_row_rule #(.WIDTH(WIDTH)) u_rule (
      .above (above_q),
      .cur   (cur_q),
      .below (rd),
      .nxt   (rule_row)
   );

   assign busy      = (state_q == ST_LOAD) || (state_q == ST_SCAN);
   assign done      = (state_q == ST_DONE);
   assign gen_count = cnt_q;

   // next-state, read address and write port; the last scanned row reads address 0 as the dead bottom border
   always_comb begin
      state_d = state_q;
      above_d = above_q;
      cur_d   = cur_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      ra      = '0;
      nwrite  = 1'b0;
      nwa     = '0;
      nwd     = '0;
      unique case (state_q)
         ST_IDLE: state_d = start ? ST_LOAD : ST_IDLE;
         ST_LOAD: begin
            ra      = REGBITS'(1);
            above_d = '0;
            cur_d   = rd;
            r_d     = REGBITS'(1);
            state_d = ST_SCAN;
         end
         ST_SCAN: begin
            ra      = r_q + 1'b1;
            nwrite  = 1'b1;
            nwa     = r_q;
            nwd     = rule_row;
            above_d = cur_q;
            cur_d   = rd;
            r_d     = r_q + 1'b1;
            state_d = (r_q == '1) ? ST_DONE : ST_SCAN;
            cnt_d   = (r_q == '1) ? cnt_q + 16'd1 : cnt_q;
         end
         ST_DONE: state_d = start ? ST_LOAD : ST_IDLE;
      endcase
   end

   // state registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         above_q <= '0;
         cur_q   <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         above_q <= above_d;
         cur_q   <= cur_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: tb/tb_gol_gen_engine.sv
// tb_gol_gen_engine: directed Game of Life patterns against hand-computed next generations
module tb_gol_gen_engine;
   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic [2:0]  ra, nwa;
   logic [7:0]  rd, nwd;
   logic        nwrite, busy, done;
   logic [15:0] gen_count;
   logic [7:0]  cur_mem [8];
   logic [7:0]  nxt_mem [8];
   logic [7:0]  exp_mem [8];
   int          errs = 0, checks = 0, exp_cnt = 0;

   assign rd = (ra == 3'd0) ? 8'h00 : cur_mem[ra];

   always #5 clk = ~clk;

   gol_gen_engine #(.WIDTH(8), .REGBITS(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .ra        (ra),
      .rd        (rd),
      .nwrite    (nwrite),
      .nwa       (nwa),
      .nwd       (nwd),
      .busy      (busy),
      .done      (done),
      .gen_count (gen_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic set_rows(input logic [63:0] cur_rows, input logic [63:0] exp_rows);
      for (int i = 0; i < 8; i++) begin
         cur_mem[i] = cur_rows[i*8 +: 8];
         exp_mem[i] = exp_rows[i*8 +: 8];
      end
   endtask

   task automatic run_gen(input string tag, input bit chained, input bit hold, input int pulse_at);
      int         done_cyc = 0, wr_n = 0, first_w = 0, last_w = 0;
      bit         ord_ok = 1'b1;
      logic       busy1 = 1'b0;
      logic [2:0] ra1 = '0, ra8 = '1;
      for (int i = 0; i < 8; i++) nxt_mem[i] = 8'hAA;
      if (!chained) begin
         @(negedge clk);
         start = 1'b1;
      end
      @(posedge clk);
      for (int k = 1; k <= 20 && done_cyc == 0; k++) begin
         @(negedge clk);
         start = hold || (k == pulse_at);
         if (k == 1) begin
            busy1 = busy;
            ra1   = ra;
         end
         if (k == 8) ra8 = ra;
         if (nwrite) begin
            nxt_mem[nwa] = nwd;
            wr_n++;
            if (first_w == 0) first_w = k;
            last_w = k;
            if (int'(nwa) != k - 1) ord_ok = 1'b0;
         end
         if (done) done_cyc = k;
      end
      exp_cnt++;
      check({tag, ".done_cycle"}, done_cyc, 9);
      check({tag, ".writes"}, wr_n, 7);
      check({tag, ".first_write"}, first_w, 2);
      check({tag, ".last_write"}, last_w, 8);
      check({tag, ".row_order"}, 32'(ord_ok), 1);
      check({tag, ".busy_load"}, 32'(busy1), 1);
      check({tag, ".ra_load"}, 32'(ra1), 1);
      check({tag, ".ra_wrap"}, 32'(ra8), 0);
      check({tag, ".busy_done"}, 32'(busy), 0);
      check({tag, ".gen_count"}, 32'(gen_count), exp_cnt);
      check({tag, ".row0"}, 32'(nxt_mem[0]), 32'h0AA);
      for (int i = 1; i < 8; i++) check($sformatf("%s.row%0d", tag, i), 32'(nxt_mem[i]), 32'(exp_mem[i]));
   endtask

   initial begin
      logic seen_done = 1'b0, seen_busy = 1'b0;
      for (int i = 0; i < 8; i++) cur_mem[i] = 8'h00;
      rst_n = 1'b0;
      start = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst.busy", 32'(busy), 0);
      check("rst.done", 32'(done), 0);
      check("rst.nwrite", 32'(nwrite), 0);
      check("rst.nwa", 32'(nwa), 0);
      check("rst.nwd", 32'(nwd), 0);
      check("rst.ra", 32'(ra), 0);
      check("rst.gen_count", 32'(gen_count), 0);
      start = 1'b0;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("rst.start_ignored", 32'(busy), 0);
      set_rows(64'h00000000_1C000000, 64'h00000008_08080000);
      run_gen("blinker", 1'b0, 1'b0, 0);
      set_rows(64'h00000018_18000000, 64'h00000018_18000000);
      run_gen("block1", 1'b0, 1'b1, 0);
      run_gen("block2", 1'b1, 1'b0, 0);
      set_rows(64'h07000000_00000000, 64'h02020000_00000000);
      run_gen("corner", 1'b0, 1'b0, 0);
`ifdef GOL_HWRAP_EN
      set_rows(64'h00000081_81000000, 64'h00000081_81000000);
`else
      set_rows(64'h00000081_81000000, 64'h00000000_00000000);
`endif
      run_gen("hwrap", 1'b0, 1'b0, 0);
      set_rows(64'h00000000_1C000000, 64'h00000008_08080000);
      run_gen("ignstart", 1'b0, 1'b0, 3);
      @(negedge clk);
      check("ignstart.no_restart", 32'(busy), 0);
      check("ignstart.count_hold", 32'(gen_count), exp_cnt);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("midrst.busy_before", 32'(busy), 1);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst.busy", 32'(busy), 0);
      check("midrst.nwrite", 32'(nwrite), 0);
      check("midrst.done", 32'(done), 0);
      check("midrst.gen_count", 32'(gen_count), 0);
      rst_n = 1'b1;
      repeat (12) begin
         @(negedge clk);
         seen_done = seen_done | done;
         seen_busy = seen_busy | busy;
      end
      check("midrst.no_done", 32'(seen_done), 0);
      check("midrst.stays_idle", 32'(seen_busy), 0);
      check("midrst.count_after", 32'(gen_count), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
